// File: rtl/obi_delay_sram.sv
// obi_delay_sram: OBI responder modelling a slow, pipelined SRAM.
// Programmable grant delay, fixed read latency and a cap on outstanding
// transactions. Optional feature macro: OBI_DELAY_SRAM_RANDOM_GNT_EN
// (per-request grant delay drawn from a 16-bit LFSR).

package obi_delay_sram_pkg;

  // OBI request from the initiator
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  // OBI response back to the initiator
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_delay_sram
  import obi_delay_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned GNT_DELAY       = 2,
  parameter int unsigned RVALID_DELAY    = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  req_i,
  output obi_resp_t resp_o
);

  localparam int unsigned AW    = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W = $clog2(GNT_DELAY + 2);
  localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W-1:0]        delay;
  logic [OST_W-1:0]        ost_q;
  logic                    slot_free;
  logic                    gnt_c;
  logic                    rvalid;
  logic [AW-1:0]           idx;
  logic [31:0]             rd_entry;
  logic [31:0]             mem_q [NUM_WORDS];
  logic [RVALID_DELAY-1:0] vld_q;
  logic [31:0]             dat_q [RVALID_DELAY];
  logic                    unused_addr;

  // Word index; upper address bits alias, byte offset is ignored
  assign idx         = req_i.addr[AW+1:2];
  assign unused_addr = ^{req_i.addr[31:AW+2], req_i.addr[1:0]};

  assign rvalid    = vld_q[RVALID_DELAY-1];
  assign slot_free = (ost_q < OST_W'(MAX_OUTSTANDING)) || rvalid;
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef OBI_DELAY_SRAM_RANDOM_GNT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign delay   = CNT_W'(lfsr_q % 16'(GNT_DELAY + 1));

  // LFSR steps once per granted request so the delay is stable while waiting
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else if (gnt_c) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign delay = CNT_W'(GNT_DELAY);
`endif

  // Grant FSM state and wait counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant FSM next state and combinational grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i.req) begin
          if ((delay == '0) && slot_free) begin
            gnt_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (!req_i.req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= delay) begin
          cnt_d = '0;
          if (slot_free) begin
            gnt_c   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_STALL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STALL: begin
        if (!req_i.req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (slot_free) begin
          gnt_c   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // No grant (and hence no access) while reset is held
    if (!rst_ni) begin
      gnt_c = 1'b0;
    end
  end

  // Outstanding counter: +1 on grant, -1 on response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ost_q <= '0;
    end else begin
      unique case ({gnt_c, rvalid})
        2'b10:   ost_q <= ost_q + OST_W'(1);
        2'b01:   ost_q <= ost_q - OST_W'(1);
        default: ost_q <= ost_q;
      endcase
    end
  end

  // Byte-masked write at the grant edge; array contents survive reset
  always_ff @(posedge clk_i) begin
    if (gnt_c && req_i.we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_i.be[b]) begin
          mem_q[idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads return the stored word; writes and idle slots carry zero
  assign rd_entry = (gnt_c && !req_i.we) ? mem_q[idx] : 32'h0;

  // Response delay line, entered at grant, flushed by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < RVALID_DELAY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= gnt_c;
      dat_q[0] <= rd_entry;
      for (int i = 1; i < RVALID_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign resp_o = '{gnt: gnt_c, rvalid: rvalid, rdata: dat_q[RVALID_DELAY-1]};

endmodule

// File: tb/tb_obi_delay_sram.sv
// Self-checking bench for obi_delay_sram: a default-parameter instance for
// latency, byte enables, aliasing and reset, plus a throttled instance
// (GNT_DELAY=0, RVALID_DELAY=6, MAX_OUTSTANDING=4) for backpressure.

module tb_obi_delay_sram;
  import obi_delay_sram_pkg::*;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic      clk;
  logic      rst_n;
  obi_req_t  req_a, req_b;
  obi_resp_t resp_a, resp_b;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int rv_cyc_a = -1;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int          rvq_b[$];

  obi_delay_sram u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req_a),
    .resp_o (resp_a)
  );

  obi_delay_sram #(
    .NUM_WORDS      (1024),
    .GNT_DELAY      (0),
    .RVALID_DELAY   (6),
    .MAX_OUTSTANDING(4)
  ) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req_b),
    .resp_o (resp_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: pop expected data on every rvalid, rdata must be 0 otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_a.rvalid) begin
        rv_cyc_a = cyc;
        if (q_a.size() == 0) chk("sb_a_unexpected_rvalid", 32'd1, 32'd0);
        else chk("sb_a_rdata", resp_a.rdata, q_a.pop_front());
      end else begin
        chk("idle_a_rdata", resp_a.rdata, 32'h0);
      end
      if (resp_b.rvalid) begin
        rvq_b.push_back(cyc);
        if (q_b.size() == 0) chk("sb_b_unexpected_rvalid", 32'd1, 32'd0);
        else chk("sb_b_rdata", resp_b.rdata, q_b.pop_front());
      end else begin
        chk("idle_b_rdata", resp_b.rdata, 32'h0);
      end
    end
  end

  // Drive one request and hold it until granted; caller is just after a posedge
  task automatic issue(input int sel, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, output int gcyc);
    obi_req_t r;
    logic     g;
    r = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
    if (sel == 0) req_a = r;
    else          req_b = r;
    gcyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      g = (sel == 0) ? resp_a.gnt : resp_b.gnt;
      if (g) begin
        gcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (gcyc < 0) begin
      chk("gnt_timeout", 32'd0, 32'd1);
    end else if (sel == 0) begin
      q_a.push_back(exp);
    end else begin
      q_b.push_back(exp);
    end
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for every expected response of one instance
  task automatic drain(input int sel);
    int sz;
    for (int k = 0; k < 60; k++) begin
      sz = (sel == 0) ? q_a.size() : q_b.size();
      if (sz == 0) break;
      @(posedge clk); #1;
    end
    sz = (sel == 0) ? q_a.size() : q_b.size();
    chk("drain", 32'(sz), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   exp_g[6];
    int   exp_rv[6];
    int   gc[6];
    int   t0;
    int   g;

    exp_g  = '{0, 1, 2, 3, 6, 7};
    exp_rv = '{6, 7, 8, 9, 12, 13};

    vecs[0] = '{1'b1, 4'hF,    32'h0000_0010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 4'hF,    32'h0000_0010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 4'b0101, 32'h0000_0010, 32'h11223344, 32'h0};
    vecs[3] = '{1'b0, 4'hF,    32'h0000_0010, 32'h0,        32'hDE22BE44};
    vecs[4] = '{1'b1, 4'hF,    32'h0000_0004, 32'hCAFE0001, 32'h0};
    vecs[5] = '{1'b0, 4'hF,    32'h0000_1004, 32'h0,        32'hCAFE0001};
    vecs[6] = '{1'b0, 4'hF,    32'h0000_0013, 32'h0,        32'hDE22BE44};

    // Reset held with a pending request: no grant, no response
    rst_n = 1'b0;
    req_a = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h10, wdata: 32'h5555_5555};
    req_b = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0,  wdata: 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt_a",    32'(resp_a.gnt),    32'd0);
      chk("rst_rvalid_a", 32'(resp_a.rvalid), 32'd0);
      chk("rst_rdata_a",  resp_a.rdata,       32'h0);
      chk("rst_gnt_b",    32'(resp_b.gnt),    32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_a = '0;
    req_b = '0;
    @(posedge clk); #1;

    // Table: latency, byte enables, aliasing, ignored byte offset
    for (int i = 0; i < 7; i++) begin
      t0 = cyc;
      issue(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp, g);
      req_a.req = 1'b0;
      drain(0);
      if (g >= 0) begin
        chk("gnt_latency",    32'(g - t0),       32'd2);
        chk("rvalid_latency", 32'(rv_cyc_a - g), 32'd3);
      end
    end

    // Throttle: preload six words, then six back-to-back reads
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b1, 4'hF, 32'(4 * i), 32'hB000_0000 | 32'(i), 32'h0, g);
    end
    req_b.req = 1'b0;
    drain(1);
    rvq_b.delete();
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, 4'hF, 32'(4 * i), 32'h0, 32'hB000_0000 | 32'(i), g);
      gc[i] = g - t0;
    end
    req_b.req = 1'b0;
    drain(1);
    for (int i = 0; i < 6; i++) begin
      chk("throttle_gnt_cycle", 32'(gc[i]), 32'(exp_g[i]));
    end
    chk("throttle_rvalid_count", 32'(rvq_b.size()), 32'd6);
    for (int i = 0; i < rvq_b.size() && i < 6; i++) begin
      chk("throttle_rvalid_cycle", 32'(rvq_b[i] - t0), 32'(exp_rv[i]));
    end

    // Reset one cycle after a read's grant, with a write attempt held in reset
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDE22BE44, g);
    rst_n = 1'b0;
    q_a.delete();
    req_a = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h10, wdata: 32'h0};
    @(negedge clk);
    chk("midrst_gnt", 32'(resp_a.gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    t0 = cyc;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDE22BE44, g);
    req_a.req = 1'b0;
    drain(0);
    if (g >= 0) chk("post_rst_gnt_latency", 32'(g - t0), 32'd2);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_a_empty", 32'(q_a.size()), 32'd0);
    chk("sb_b_empty", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_delay_sram.md
# obi_delay_sram

OBI responder that models a slow, pipelined SRAM on one external-bus slave port of the test harness (the slow-memory slot). It accepts OBI requests with a programmable grant delay and returns in-order responses exactly a fixed number of cycles after grant. It bounds the number of outstanding transactions, so the initiator-side handshakes of X-HEEP and its DMA can be exercised against realistic latency and backpressure.

## Interface
Parameters:
- NUM_WORDS, 1024: 32-bit words in the array. Must be a power of two, ≥2.
- GNT_DELAY, 2: cycles a request is held before `gnt` (0 = same-cycle grant).
- RVALID_DELAY, 3: cycles from the `gnt` edge to `rvalid`. Must be ≥1.
- MAX_OUTSTANDING, 4: granted-but-unanswered transactions allowed. Must be ≥1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  obi_req_t  fields `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`.
- resp_o  out  obi_resp_t  fields `gnt`, `rvalid`, `rdata[31:0]`.

## Operation
- Word index is `addr[$clog2(NUM_WORDS)+1:2]`.
  - Higher bits are ignored, so addresses alias modulo NUM_WORDS*4.
  - `addr[1:0]` is ignored.
- Grant FSM:
  - IDLE: `req`=1 and GNT_DELAY=0 and a slot is free → `gnt` this cycle, stay IDLE. Otherwise `req`=1 → WAIT, with the wait counter cleared.
  - WAIT: the counter increments each cycle `req` stays high. When it reaches GNT_DELAY:
    - slot free → `gnt`, go to IDLE;
    - slot not free → go to STALL.
  - STALL: `gnt` is asserted in the first cycle a slot is free, then go to IDLE.
  - A slot is free when outstanding < MAX_OUTSTANDING, or when `rvalid` is asserted in the same cycle.
  - `req` dropping before `gnt` (illegal in OBI, but tolerated) → IDLE with the counter cleared. No access takes place.
  - If `req` stays high after `gnt`, that is a new request and its delay restarts from 0. Sustained throughput is therefore 1/(GNT_DELAY+1).
- Access at the `gnt` edge:
  - Write: only bytes with `be`=1 are updated.
  - Read: the word is sampled after any same-edge write to the array. Read-after-write in issue order always returns the new data.
- Response pipeline: an RVALID_DELAY-stage shift register of {valid, rdata}, entered at grant.
  - Writes carry rdata=0.
  - The last stage drives `rvalid` and `rdata`. There is no backpressure.
- Outstanding counter:
  - +1 on `gnt`, −1 on `rvalid`.
  - Both in the same cycle → unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Reset mid-operation:
  - All in-flight responses are discarded and never produce `rvalid`.
  - Counter → 0, FSM → IDLE.
  - The memory array is not reset; contents are retained.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, outstanding=0, FSM=IDLE.
- `gnt` is combinational from `req_i.req`, FSM state, counter and the outstanding/`rvalid` state. There is no combinational path from `we`, `addr` or `wdata`.
- `rvalid` and `rdata` are registered.
  - For a request first seen high in cycle t with a free slot: `gnt` in cycle t+GNT_DELAY, `rvalid` in cycle t+GNT_DELAY+RVALID_DELAY.
  - `rdata`=0 in every cycle where `rvalid`=0.
- Responses are strictly in grant order, with exactly one `rvalid` per `gnt`.

## Configuration
- `OBI_DELAY_SRAM_RANDOM_GNT_EN` defined:
  - Each new request's grant delay is `lfsr % (GNT_DELAY+1)`.
  - `lfsr` is a 16-bit Fibonacci LFSR with taps 16,14,13,11 and reset seed 16'hACE1.
  - It advances one step per granted request.
  - RVALID_DELAY stays fixed.
- Not defined: the grant delay is exactly GNT_DELAY and no LFSR logic is present.

## Test plan
1. Reset: hold `rst_ni`=0 for 3 cycles with `req`=1 → `gnt`=0, `rvalid`=0, `rdata`=0 in every cycle; no write occurs.
2. Defaults: write 32'hDEADBEEF to 0x10 with `be`=4'hF, `req` rising in cycle 0 → `gnt` in cycle 2, `rvalid` in cycle 5 with `rdata`=0. A following read of 0x10 → `rdata`=32'hDEADBEEF.
3. Byte enables: over 32'hDEADBEEF, write 32'h11223344 with `be`=4'b0101 → readback 32'hDE22BE44.
4. Throttle: GNT_DELAY=0, RVALID_DELAY=6, MAX_OUTSTANDING=4, with 6 back-to-back reads.
   - `gnt` in cycles 0–3, no `gnt` in cycles 4–5.
   - `rvalid` in cycles 6–9, with `gnt` simultaneously in cycles 6 and 7.
   - Data is returned in order.
5. Aliasing: NUM_WORDS=1024, write 32'hCAFE0001 to 0x0000_0004, then read 0x0000_1004 → 32'hCAFE0001.
6. Reset mid-operation: assert `rst_ni`=0 one cycle after the `gnt` of a read → no `rvalid` for it. After reset, a new read gets `gnt` in cycle +GNT_DELAY, showing the outstanding count is 0. Previously written memory data is intact.
